alu_issue: RTL and testbench
============================

# alu_issue

Registered decode/issue stage that drives the RV32I ALU. It accepts one 32-bit instruction per handshake with its PC and register-file read data, decodes the instruction, and generates the immediate. It presents the ALU operands, the 4-bit ALU operation code and write-back/memory control to the execute stage through a one-entry valid/ready pipeline register.

## Interface
- No parameters; XLEN fixed at 32.
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  drop held entry and any input accepted this cycle
- in_valid_i  in  1  instruction bundle valid
- in_ready_o  out  1  stage can accept bundle
- instr_i  in  32  instruction word
- pc_i  in  32  instruction address
- rs1_data_i, rs2_data_i  in  32  register-file read data
- out_valid_o  out  1  issued bundle valid
- out_ready_i  in  1  execute stage accepts bundle
- a_o, b_o  out  32  ALU operands
- alu_op_o  out  4  0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SRA, 1000 SLT, 1001 SLTU
- imm_o  out  32  sign-extended immediate (branch/jump target use)
- store_data_o  out  32  rs2_data for stores
- rd_o  out  5  destination register
- rd_we_o  out  1  write-back enable; forced 0 when rd_o==0
- is_load_o, is_store_o, is_branch_o, is_jalr_o  out  1  class flags
- funct3_o  out  3  instr[14:12] passthrough
- illegal_o  out  1  unsupported encoding

## Operation
- Decode by opcode:
  - OP 0110011: a=rs1, b=rs2. The funct3/funct7 pair selects ADD/SUB (funct7 0x00/0x20), SLL, SLT, SLTU, XOR, SRL/SRA (0x00/0x20), OR, AND. Any other funct7 is illegal.
  - OP-IMM 0010011: a=rs1, b=I-imm, same funct3 map with no SUB. For SLLI, imm[11:5] must be 0. For SRLI/SRAI, imm[11:5] must be 0x00/0x20; otherwise illegal.
  - LOAD 0000011: ADD rs1+I-imm, is_load=1, rd_we=1.
  - STORE 0100011: ADD rs1+S-imm, is_store=1, rd_we=0.
  - BRANCH 1100011: SUB rs1-rs2, is_branch=1, imm=B-imm, rd_we=0.
  - LUI 0110111: a=0, b=U-imm, ADD.
  - AUIPC 0010111: a=pc, b=U-imm, ADD.
  - JAL 1101111: a=pc, b=4, ADD, imm=J-imm.
  - JALR 1100111: a=pc, b=4, ADD, is_jalr=1, imm=I-imm. funct3≠000 is illegal.
- Illegal or unknown opcode: illegal_o=1, a=b=0, alu_op=ADD, rd_we=0, all class flags 0. The bundle still issues.
- All immediates are sign-extended from instr[31]. U-imm = {instr[31:12], 12'b0}.
- Two states: EMPTY (out_valid_o=0) and FULL (out_valid_o=1).
- in_ready_o = !out_valid_o || out_ready_i. This is a combinational path from out_ready_i.
- Accept when in_valid_i && in_ready_o; the register loads decoded bundle.
- Transitions: EMPTY→FULL on accept. FULL→EMPTY on out_ready_i with no accept. FULL→FULL on simultaneous drain and accept (full throughput, one per cycle).
- flush_i=1: the next state is EMPTY regardless of in_valid_i/out_ready_i. Flush has priority over accept.

## Timing
- Latency: accepted at edge N → out_valid_o=1 with payload after edge N.
- While out_valid_o && !out_ready_i, every output is held stable. in_ready_o=0.
- Payload registers update only on accept. Payload is don't-care when out_valid_o=0 but holds the last value.
- Reset (asynchronous, any cycle including mid-stall): all outputs 0, alu_op_o=0000, state EMPTY. First accept possible on the first edge after rst_ni deasserts.
- in_valid_i is not required to stay high without acceptance. The stage samples only on accept.

## Test plan
- ADD x3,x1,x2 (0x002081B3), rs1=5, rs2=7 → next cycle: out_valid=1, a=5, b=7, alu_op=0000, rd=3, rd_we=1.
- SRAI x5,x6,4 (0x40435293), rs1=0x80000000 → alu_op=0111, b=0x00000404, rd=5. AUIPC x1,0x12345 (0x12345097), pc=0x100 → a=0x100, b=0x12345000, alu_op=0000.
- Back-to-back: three ADDIs with out_ready_i=1 → three consecutive valid cycles. Then drop out_ready_i for 2 cycles with a fourth instruction pending → in_ready_o=0 and outputs stable. The fourth issues one cycle after out_ready_i rises.
- flush_i=1 while FULL and in_valid_i=1 → out_valid=0 next cycle, input not consumed (in_ready_o was 1 but no issue).
- 0xFFFFFFFF → illegal_o=1, rd_we=0, a=b=0. ADDI x0,x1,1 → rd_we=0. BEQ → alu_op=0001, is_branch=1, rd_we=0.
- Assert rst_ni low mid-stall while FULL → all outputs 0 immediately. After release, in_ready_o=1.

Source files
------------

// File: rtl/alu_issue.sv
// RV32I decode/issue stage: decodes one instruction per handshake into ALU operands,
// op code and control, held in a one-entry valid/ready pipeline register.
module alu_issue (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        flush_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] rs1_data_i,
    input  logic [31:0] rs2_data_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] a_o,
    output logic [31:0] b_o,
    output logic [3:0]  alu_op_o,
    output logic [31:0] imm_o,
    output logic [31:0] store_data_o,
    output logic [4:0]  rd_o,
    output logic        rd_we_o,
    output logic        is_load_o,
    output logic        is_store_o,
    output logic        is_branch_o,
    output logic        is_jalr_o,
    output logic [2:0]  funct3_o,
    output logic        illegal_o
);

    localparam logic [3:0] OpAdd  = 4'b0000;
    localparam logic [3:0] OpSub  = 4'b0001;
    localparam logic [3:0] OpAnd  = 4'b0010;
    localparam logic [3:0] OpOr   = 4'b0011;
    localparam logic [3:0] OpXor  = 4'b0100;
    localparam logic [3:0] OpSll  = 4'b0101;
    localparam logic [3:0] OpSrl  = 4'b0110;
    localparam logic [3:0] OpSra  = 4'b0111;
    localparam logic [3:0] OpSlt  = 4'b1000;
    localparam logic [3:0] OpSltu = 4'b1001;

    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;

    localparam logic [6:0] F7Zero = 7'h00;
    localparam logic [6:0] F7Alt  = 7'h20;

    typedef enum logic {StEmpty, StFull} state_e;

    state_e      r_state;
    logic [31:0] r_a, r_b, r_imm, r_sd;
    logic [3:0]  r_op;
    logic [4:0]  r_rd;
    logic [2:0]  r_f3;
    logic        r_we, r_ld, r_st, r_br, r_jalr, r_ill;

    logic [6:0]  w_opcode, w_f7;
    logic [2:0]  w_f3;
    logic [4:0]  w_rd;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic [31:0] w_a, w_b, w_imm, w_sd;
    logic [3:0]  w_op;
    logic        w_we, w_ld, w_st, w_br, w_jalr, w_ill, w_rd_we;
    logic        w_accept;

    // alt selects SUB (funct3 000) or SRA (funct3 101); ignored elsewhere
    function automatic logic [3:0] f3_to_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? OpSub : OpAdd;
            3'b001:  return OpSll;
            3'b010:  return OpSlt;
            3'b011:  return OpSltu;
            3'b100:  return OpXor;
            3'b101:  return alt ? OpSra : OpSrl;
            3'b110:  return OpOr;
            default: return OpAnd;
        endcase
    endfunction

    assign w_opcode = instr_i[6:0];
    assign w_rd     = instr_i[11:7];
    assign w_f3     = instr_i[14:12];
    assign w_f7     = instr_i[31:25];

    assign w_imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
    assign w_imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign w_imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                      instr_i[11:8], 1'b0};
    assign w_imm_u = {instr_i[31:12], 12'b0};
    assign w_imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                      instr_i[30:21], 1'b0};

    always_comb begin
        w_a    = '0;
        w_b    = '0;
        w_op   = OpAdd;
        w_imm  = '0;
        w_sd   = '0;
        w_we   = 1'b0;
        w_ld   = 1'b0;
        w_st   = 1'b0;
        w_br   = 1'b0;
        w_jalr = 1'b0;
        w_ill  = 1'b0;
        case (w_opcode)
            OpcOp: begin
                w_a   = rs1_data_i;
                w_b   = rs2_data_i;
                w_we  = 1'b1;
                w_op  = f3_to_op(w_f3, w_f7 == F7Alt);
                w_ill = !((w_f7 == F7Zero) ||
                          (w_f7 == F7Alt && (w_f3 == 3'b000 || w_f3 == 3'b101)));
            end
            OpcOpImm: begin
                w_a   = rs1_data_i;
                w_b   = w_imm_i;
                w_imm = w_imm_i;
                w_we  = 1'b1;
                w_op  = f3_to_op(w_f3, w_f3 == 3'b101 && w_f7 == F7Alt);
                w_ill = (w_f3 == 3'b001 && w_f7 != F7Zero) ||
                        (w_f3 == 3'b101 && w_f7 != F7Zero && w_f7 != F7Alt);
            end
            OpcLoad: begin
                w_a   = rs1_data_i;
                w_b   = w_imm_i;
                w_imm = w_imm_i;
                w_we  = 1'b1;
                w_ld  = 1'b1;
            end
            OpcStore: begin
                w_a   = rs1_data_i;
                w_b   = w_imm_s;
                w_imm = w_imm_s;
                w_sd  = rs2_data_i;
                w_st  = 1'b1;
            end
            OpcBranch: begin
                w_a   = rs1_data_i;
                w_b   = rs2_data_i;
                w_op  = OpSub;
                w_imm = w_imm_b;
                w_br  = 1'b1;
            end
            OpcLui: begin
                w_b   = w_imm_u;
                w_imm = w_imm_u;
                w_we  = 1'b1;
            end
            OpcAuipc: begin
                w_a   = pc_i;
                w_b   = w_imm_u;
                w_imm = w_imm_u;
                w_we  = 1'b1;
            end
            OpcJal: begin
                w_a   = pc_i;
                w_b   = 32'd4;
                w_imm = w_imm_j;
                w_we  = 1'b1;
            end
            OpcJalr: begin
                w_a    = pc_i;
                w_b    = 32'd4;
                w_imm  = w_imm_i;
                w_we   = 1'b1;
                w_jalr = 1'b1;
                w_ill  = (w_f3 != 3'b000);
            end
            default: w_ill = 1'b1;
        endcase
        // Illegal bundles still issue, but as an inert ADD 0+0 with no side effects
        if (w_ill) begin
            w_a    = '0;
            w_b    = '0;
            w_op   = OpAdd;
            w_imm  = '0;
            w_sd   = '0;
            w_we   = 1'b0;
            w_ld   = 1'b0;
            w_st   = 1'b0;
            w_br   = 1'b0;
            w_jalr = 1'b0;
        end
    end

    assign w_rd_we     = w_we && (w_rd != 5'd0);
    assign out_valid_o = (r_state == StFull);
    assign in_ready_o  = !out_valid_o || out_ready_i;
    assign w_accept    = in_valid_i && in_ready_o && !flush_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= StEmpty;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= OpAdd;
            r_imm   <= '0;
            r_sd    <= '0;
            r_rd    <= '0;
            r_f3    <= '0;
            r_we    <= 1'b0;
            r_ld    <= 1'b0;
            r_st    <= 1'b0;
            r_br    <= 1'b0;
            r_jalr  <= 1'b0;
            r_ill   <= 1'b0;
        end else begin
            if (flush_i) begin
                r_state <= StEmpty;
            end else if (w_accept) begin
                r_state <= StFull;
            end else if (out_ready_i) begin
                r_state <= StEmpty;
            end
            if (w_accept) begin
                r_a    <= w_a;
                r_b    <= w_b;
                r_op   <= w_op;
                r_imm  <= w_imm;
                r_sd   <= w_sd;
                r_rd   <= w_rd;
                r_f3   <= w_f3;
                r_we   <= w_rd_we;
                r_ld   <= w_ld;
                r_st   <= w_st;
                r_br   <= w_br;
                r_jalr <= w_jalr;
                r_ill  <= w_ill;
            end
        end
    end

    assign a_o          = r_a;
    assign b_o          = r_b;
    assign alu_op_o     = r_op;
    assign imm_o        = r_imm;
    assign store_data_o = r_sd;
    assign rd_o         = r_rd;
    assign rd_we_o      = r_we;
    assign is_load_o    = r_ld;
    assign is_store_o   = r_st;
    assign is_branch_o  = r_br;
    assign is_jalr_o    = r_jalr;
    assign funct3_o     = r_f3;
    assign illegal_o    = r_ill;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed cases plus randomized traffic checked against a
// behavioural decode model and a one-entry occupancy model.
module tb_alu_issue;

    logic        clk_i = 1'b0;
    logic        rst_ni, flush_i, in_valid_i, out_ready_i;
    logic [31:0] instr_i, pc_i, rs1_data_i, rs2_data_i;
    logic        in_ready_o, out_valid_o;
    logic [31:0] a_o, b_o, imm_o, store_data_o;
    logic [3:0]  alu_op_o;
    logic [4:0]  rd_o;
    logic [2:0]  funct3_o;
    logic        rd_we_o, is_load_o, is_store_o, is_branch_o, is_jalr_o, illegal_o;

    alu_issue dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .flush_i      (flush_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .instr_i      (instr_i),
        .pc_i         (pc_i),
        .rs1_data_i   (rs1_data_i),
        .rs2_data_i   (rs2_data_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .a_o          (a_o),
        .b_o          (b_o),
        .alu_op_o     (alu_op_o),
        .imm_o        (imm_o),
        .store_data_o (store_data_o),
        .rd_o         (rd_o),
        .rd_we_o      (rd_we_o),
        .is_load_o    (is_load_o),
        .is_store_o   (is_store_o),
        .is_branch_o  (is_branch_o),
        .is_jalr_o    (is_jalr_o),
        .funct3_o     (funct3_o),
        .illegal_o    (illegal_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [31:0] a, b, imm, sd;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        we, ld, st, br, jalr, ill;
    } bundle_t;

    bundle_t m_pay;
    logic    m_valid;

    function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
        return 32'($signed(v << (32 - bits)) >>> (32 - bits));
    endfunction

    function automatic bundle_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                           input logic [31:0] r1, input logic [31:0] r2);
        // funct3 -> op: ADD SLL SLT SLTU XOR SRL OR AND
        logic [3:0] f3_tbl [8] = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};
        bundle_t    r = '0;
        logic [6:0] opc = ins[6:0];
        logic [2:0] f3 = ins[14:12];
        logic [6:0] f7 = ins[31:25];
        logic [31:0] ii = sext({20'b0, ins[31:20]}, 12);
        logic [31:0] si = sext({20'b0, ins[31:25], ins[11:7]}, 12);
        logic [31:0] bi = sext({19'b0, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}, 13);
        logic [31:0] ui = ins & 32'hFFFF_F000;
        logic [31:0] ji = sext({11'b0, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}, 21);
        logic        wb = 1'b0;
        r.f3 = f3;
        r.rd = ins[11:7];
        if (opc == 7'h33) begin
            r.a = r1; r.b = r2; wb = 1'b1; r.op = f3_tbl[f3];
            if (f7 == 7'h20 && f3 == 3'd0)      r.op = 4'd1;
            else if (f7 == 7'h20 && f3 == 3'd5) r.op = 4'd7;
            else if (f7 != 7'h00)               r.ill = 1'b1;
        end else if (opc == 7'h13) begin
            r.a = r1; r.b = ii; r.imm = ii; wb = 1'b1; r.op = f3_tbl[f3];
            if (f3 == 3'd1 && f7 != 7'h00) r.ill = 1'b1;
            if (f3 == 3'd5) begin
                if (f7 == 7'h20)      r.op = 4'd7;
                else if (f7 != 7'h00) r.ill = 1'b1;
            end
        end else if (opc == 7'h03) begin
            r.a = r1; r.b = ii; r.imm = ii; wb = 1'b1; r.ld = 1'b1;
        end else if (opc == 7'h23) begin
            r.a = r1; r.b = si; r.imm = si; r.sd = r2; r.st = 1'b1;
        end else if (opc == 7'h63) begin
            r.a = r1; r.b = r2; r.op = 4'd1; r.imm = bi; r.br = 1'b1;
        end else if (opc == 7'h37) begin
            r.b = ui; r.imm = ui; wb = 1'b1;
        end else if (opc == 7'h17) begin
            r.a = pc; r.b = ui; r.imm = ui; wb = 1'b1;
        end else if (opc == 7'h6F) begin
            r.a = pc; r.b = 4; r.imm = ji; wb = 1'b1;
        end else if (opc == 7'h67) begin
            r.a = pc; r.b = 4; r.imm = ii; wb = 1'b1; r.jalr = 1'b1;
            if (f3 != 3'd0) r.ill = 1'b1;
        end else begin
            r.ill = 1'b1;
        end
        if (r.ill) begin
            r = '0;
            r.ill = 1'b1;
            r.f3 = f3;
            r.rd = ins[11:7];
        end else begin
            r.we = wb && (ins[11:7] != 0);
        end
        return r;
    endfunction

    task automatic compare_outputs();
        check("out_valid", out_valid_o, m_valid);
        check("a", a_o, m_pay.a);
        check("b", b_o, m_pay.b);
        check("alu_op", alu_op_o, m_pay.op);
        check("imm", imm_o, m_pay.imm);
        check("store_data", store_data_o, m_pay.sd);
        check("rd", rd_o, m_pay.rd);
        check("funct3", funct3_o, m_pay.f3);
        check("rd_we", rd_we_o, m_pay.we);
        check("is_load", is_load_o, m_pay.ld);
        check("is_store", is_store_o, m_pay.st);
        check("is_branch", is_branch_o, m_pay.br);
        check("is_jalr", is_jalr_o, m_pay.jalr);
        check("illegal", illegal_o, m_pay.ill);
    endtask

    // One clock: check held outputs, drive inputs, check in_ready, advance the model.
    task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic [31:0] r1, input logic [31:0] r2,
                         input logic ordy, input logic fl);
        logic acc;
        @(negedge clk_i);
        compare_outputs();
        in_valid_i  = v;
        instr_i     = ins;
        pc_i        = pc;
        rs1_data_i  = r1;
        rs2_data_i  = r2;
        out_ready_i = ordy;
        flush_i     = fl;
        #1;
        check("in_ready", in_ready_o, !m_valid || ordy);
        acc = v && (!m_valid || ordy) && !fl;
        @(posedge clk_i);
        if (fl)        m_valid = 1'b0;
        else if (acc)  m_valid = 1'b1;
        else if (ordy) m_valid = 1'b0;
        if (acc) m_pay = ref_decode(ins, pc, r1, r2);
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  opcs [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67};
        logic [31:0] w = $urandom;
        int          k = $urandom_range(0, 11);
        if (k < 9) begin
            w[6:0] = opcs[k];
            if ($urandom_range(0, 3) != 0) w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
            if ($urandom_range(0, 3) == 0) w[14:12] = 3'd0;
        end
        return w;
    endfunction

    initial begin
        rst_ni = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
        instr_i = '0; pc_i = '0; rs1_data_i = '0; rs2_data_i = '0;
        m_valid = 1'b0; m_pay = '0;
        #12;
        compare_outputs();
        check("reset_in_ready", in_ready_o, 1'b1);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // ADD x3,x1,x2
        cycle(1'b1, 32'h002081B3, 32'h0, 32'd5, 32'd7, 1'b1, 1'b0);
        check("add_valid", out_valid_o, 1'b1);
        check("add_a", a_o, 32'd5);
        check("add_b", b_o, 32'd7);
        check("add_op", alu_op_o, 4'b0000);
        check("add_rd", rd_o, 5'd3);
        check("add_we", rd_we_o, 1'b1);
        // SRAI x5,x6,4
        cycle(1'b1, 32'h40435293, 32'h0, 32'h8000_0000, 32'h0, 1'b1, 1'b0);
        check("srai_op", alu_op_o, 4'b0111);
        check("srai_b", b_o, 32'h0000_0404);
        check("srai_rd", rd_o, 5'd5);
        // AUIPC x1,0x12345
        cycle(1'b1, 32'h12345097, 32'h100, 32'h0, 32'h0, 1'b1, 1'b0);
        check("auipc_a", a_o, 32'h100);
        check("auipc_b", b_o, 32'h1234_5000);
        check("auipc_op", alu_op_o, 4'b0000);

        // Three back-to-back ADDIs, then a fourth stalled for two cycles
        for (int i = 1; i <= 3; i++) begin
            cycle(1'b1, {12'(i), 5'd1, 3'd0, 5'd2, 7'h13}, 32'h0, 32'd10, 32'h0, 1'b1, 1'b0);
            check("b2b_valid", out_valid_o, 1'b1);
            check("b2b_b", b_o, 32'(i));
        end
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 32'h00408113, 32'h0, 32'd10, 32'h0, 1'b0, 1'b0);
            check("stall_b", b_o, 32'd3);
        end
        cycle(1'b1, 32'h00408113, 32'h0, 32'd10, 32'h0, 1'b1, 1'b0);
        check("fourth_b", b_o, 32'd4);

        // Flush while FULL with a pending input
        cycle(1'b1, 32'h00508113, 32'h0, 32'd10, 32'h0, 1'b1, 1'b1);
        check("flush_valid", out_valid_o, 1'b0);
        check("flush_b_kept", b_o, 32'd4);

        cycle(1'b1, 32'hFFFF_FFFF, 32'h40, 32'd9, 32'd9, 1'b1, 1'b0);
        check("ill_flag", illegal_o, 1'b1);
        check("ill_we", rd_we_o, 1'b0);
        check("ill_a", a_o, 32'h0);
        check("ill_b", b_o, 32'h0);
        cycle(1'b1, 32'h00108013, 32'h0, 32'd1, 32'h0, 1'b1, 1'b0);
        check("addi_x0_we", rd_we_o, 1'b0);
        cycle(1'b1, 32'h00208463, 32'h0, 32'd1, 32'd2, 1'b1, 1'b0);
        check("beq_op", alu_op_o, 4'b0001);
        check("beq_br", is_branch_o, 1'b1);
        check("beq_we", rd_we_o, 1'b0);
        check("beq_imm", imm_o, 32'd8);

        // Reset asserted mid-stall
        cycle(1'b1, 32'h00A00093, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        #2;
        rst_ni = 1'b0;
        #1;
        m_valid = 1'b0;
        m_pay   = '0;
        compare_outputs();
        check("rst_in_ready", in_ready_o, 1'b1);
        @(negedge clk_i);
        rst_ni = 1'b1;

        for (int i = 0; i < 2000; i++) begin
            cycle($urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom, $urandom,
                  $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
        end
        @(negedge clk_i);
        compare_outputs();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
